mem_port_ctrl: RTL and testbench

MEM_PORT_CTRL -- requirements
Module: mem_port_ctrl

---
 rtl/mem_port_ctrl_if.sv | 44 ++++
 rtl/mem_port_ctrl.sv | 114 +++++++++++
 tb/tb_mem_port_ctrl.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_ctrl_if.sv
// Client request/response and RAM port bundle for mem_port_ctrl.
// The slave modport is the controller side; master is the client/RAM environment.
`ifndef MEMORY_ADDR_WIDTH
`define MEMORY_ADDR_WIDTH 11
`endif
`ifndef MEMORY_DATA_WIDTH
`define MEMORY_DATA_WIDTH 16
`endif

interface mem_port_ctrl_if #(
  parameter int A = `MEMORY_ADDR_WIDTH,
  parameter int D = `MEMORY_DATA_WIDTH
);
  logic         req_valid;
  logic         req_ready;
  logic [1:0]   req_op;
  logic [A-1:0] req_addr1;
  logic [A-1:0] req_addr2;
  logic [D-1:0] req_data;
  logic         resp_valid;
  logic         resp_ready;
  logic [D-1:0] resp_q1;
  logic [D-1:0] resp_q2;
  logic         resp_err;
  logic [7:0]   err_count;
  logic [A-1:0] mem_address1;
  logic [A-1:0] mem_address2;
  logic [D-1:0] mem_data;
  logic         mem_wren;
  logic [D-1:0] mem_q1;
  logic [D-1:0] mem_q2;

  modport master (
    output req_valid, req_op, req_addr1, req_addr2, req_data, resp_ready, mem_q1, mem_q2,
    input  req_ready, resp_valid, resp_q1, resp_q2, resp_err, err_count,
           mem_address1, mem_address2, mem_data, mem_wren
  );

  modport slave (
    input  req_valid, req_op, req_addr1, req_addr2, req_data, resp_ready, mem_q1, mem_q2,
    output req_ready, resp_valid, resp_q1, resp_q2, resp_err, err_count,
           mem_address1, mem_address2, mem_data, mem_wren
  );
endinterface

// File: rtl/mem_port_ctrl.sv
// Single-outstanding RAM port controller: range-checks client requests, runs one
// read, pair read or write against a one-cycle-latency RAM and holds the response.
module mem_port_ctrl #(
  parameter int ADDR_LIMIT = 1024
) (
  input  logic           clock,
  input  logic           reset,
  mem_port_ctrl_if.slave bus
);
  localparam int A = `MEMORY_ADDR_WIDTH;
  localparam int D = `MEMORY_DATA_WIDTH;
  localparam logic [A:0] LIMIT = (A+1)'(ADDR_LIMIT);

  localparam logic [1:0] OP_PAIR  = 2'b01;
  localparam logic [1:0] OP_WRITE = 2'b10;
  localparam logic [1:0] OP_RSVD  = 2'b11;

  typedef enum logic [2:0] {IDLE, ISSUE, CAPTURE, WRITE, RESP} state_t;

  state_t       state_q;
  logic         isPair_q;
  logic         resp_valid_q;
  logic         resp_err_q;
  logic [D-1:0] resp_q1_q;
  logic [D-1:0] resp_q2_q;
  logic [7:0]   err_count_q;
  logic [A-1:0] mem_address1_q;
  logic [A-1:0] mem_address2_q;
  logic [D-1:0] mem_data_q;
  logic         mem_wren_q;

  logic addr1Bad;
  logic addr2Bad;
  logic reqErr;

  // The secondary address only matters for a pair read
  assign addr1Bad = ({1'b0, bus.req_addr1} >= LIMIT);
  assign addr2Bad = ({1'b0, bus.req_addr2} >= LIMIT);
  assign reqErr   = (bus.req_op == OP_RSVD) | addr1Bad | ((bus.req_op == OP_PAIR) & addr2Bad);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      isPair_q       <= 1'b0;
      resp_valid_q   <= 1'b0;
      resp_err_q     <= 1'b0;
      resp_q1_q      <= '0;
      resp_q2_q      <= '0;
      err_count_q    <= '0;
      mem_address1_q <= '0;
      mem_address2_q <= '0;
      mem_data_q     <= '0;
      mem_wren_q     <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            if (reqErr) begin
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              if (err_count_q != 8'hFF) err_count_q <= err_count_q + 8'd1;
              state_q      <= RESP;
            end else if (bus.req_op == OP_WRITE) begin
              mem_address1_q <= bus.req_addr1;
              mem_data_q     <= bus.req_data;
              mem_wren_q     <= 1'b1;
              state_q        <= WRITE;
            end else begin
              isPair_q       <= (bus.req_op == OP_PAIR);
              mem_address1_q <= bus.req_addr1;
              mem_address2_q <= (bus.req_op == OP_PAIR) ? bus.req_addr2 : bus.req_addr1;
              mem_wren_q     <= 1'b0;
              state_q        <= ISSUE;
            end
          end
        end
        ISSUE: state_q <= CAPTURE;
        CAPTURE: begin
          // RAM data is valid now, one cycle after the ISSUE edge sampled the address
          resp_q1_q    <= bus.mem_q1;
          resp_q2_q    <= isPair_q ? bus.mem_q2 : bus.mem_q1;
          resp_valid_q <= 1'b1;
          resp_err_q   <= 1'b0;
          state_q      <= RESP;
        end
        WRITE: begin
          mem_wren_q   <= 1'b0;
          resp_valid_q <= 1'b1;
          resp_err_q   <= 1'b0;
          state_q      <= RESP;
        end
        RESP: begin
          if (bus.resp_ready) begin
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready    = (state_q == IDLE);
  assign bus.resp_valid   = resp_valid_q;
  assign bus.resp_err     = resp_err_q;
  assign bus.resp_q1      = resp_q1_q;
  assign bus.resp_q2      = resp_q2_q;
  assign bus.err_count    = err_count_q;
  assign bus.mem_address1 = mem_address1_q;
  assign bus.mem_address2 = mem_address2_q;
  assign bus.mem_data     = mem_data_q;
  assign bus.mem_wren     = mem_wren_q;
endmodule

// File: tb/tb_mem_port_ctrl.sv
// Randomized bench for mem_port_ctrl: a transaction-level model predicts every
// output each cycle from operation latencies and a shadow memory.
`ifndef MEMORY_ADDR_WIDTH
`define MEMORY_ADDR_WIDTH 11
`endif
`ifndef MEMORY_DATA_WIDTH
`define MEMORY_DATA_WIDTH 16
`endif

module tb_mem_port_ctrl;
  localparam int A     = `MEMORY_ADDR_WIDTH;
  localparam int D     = `MEMORY_DATA_WIDTH;
  localparam int LIMIT = 1024;

  logic clock = 1'b0;
  logic reset = 1'b1;

  mem_port_ctrl_if #(.A(A), .D(D)) bus ();

  mem_port_ctrl #(.ADDR_LIMIT(LIMIT)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  logic [D-1:0] ram [2**A];
  int expMem [LIMIT];

  // Synchronous RAM: data appears the cycle after the edge that sampled the address
  always @(posedge clock) begin
    if (bus.mem_wren === 1'b1) ram[bus.mem_address1] <= bus.mem_data;
    bus.mem_q1 <= ram[bus.mem_address1];
    bus.mem_q2 <= ram[bus.mem_address2];
  end

  int expReady = 1, expValid = 0, expErr = 0, expQ1 = 0, expQ2 = 0, expErrCnt = 0;
  int expAddr1 = 0, expAddr2 = 0, expData = 0, expWren = 0;
  int checkCount = 0, passCount = 0, wrenCount = 0;
  int lastQ1 = 0, lastQ2 = 0, lastErr = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clock) if (bus.mem_wren === 1'b1) wrenCount++;

  initial forever begin
    @(negedge clock);
    checkOutput("req_ready",    32'(bus.req_ready),    expReady);
    checkOutput("resp_valid",   32'(bus.resp_valid),   expValid);
    checkOutput("resp_err",     32'(bus.resp_err),     expErr);
    checkOutput("resp_q1",      32'(bus.resp_q1),      expQ1);
    checkOutput("resp_q2",      32'(bus.resp_q2),      expQ2);
    checkOutput("err_count",    32'(bus.err_count),    expErrCnt);
    checkOutput("mem_address1", 32'(bus.mem_address1), expAddr1);
    checkOutput("mem_address2", 32'(bus.mem_address2), expAddr2);
    checkOutput("mem_data",     32'(bus.mem_data),     expData);
    checkOutput("mem_wren",     32'(bus.mem_wren),     expWren);
  end

  task automatic setResetExpect();
    expReady = 1; expValid = 0; expErr = 0; expQ1 = 0; expQ2 = 0; expErrCnt = 0;
    expAddr1 = 0; expAddr2 = 0; expData = 0; expWren = 0;
  endtask

  task automatic randomizeReq();
    bus.req_op    = 2'($urandom);
    bus.req_addr1 = A'($urandom);
    bus.req_addr2 = A'($urandom);
    bus.req_data  = D'($urandom);
  endtask

  task automatic doAbort();
    reset = 1'b0;
    setResetExpect();
    #1;
    checkOutput("abort_resp_valid", 32'(bus.resp_valid), 0);
    checkOutput("abort_wren",       32'(bus.mem_wren),    0);
    @(posedge clock); #1;
    reset = 1'b1;
  endtask

  // Called one time unit after an edge with the controller idle; returns likewise
  task automatic applyStimulus(input int op, input int a1, input int a2, input int d,
                               input int hold, input bit offer, input bit abort);
    bit isErr;
    int oldVal;
    bus.req_valid = 1'b1;
    bus.req_op    = 2'(op);
    bus.req_addr1 = A'(a1);
    bus.req_addr2 = A'(a2);
    bus.req_data  = D'(d);
    @(posedge clock); #1;
    bus.req_valid = 1'b0;
    randomizeReq();
    expReady = 0;
    isErr = (op == 3) || (a1 >= LIMIT) || (op == 1 && a2 >= LIMIT);
    if (isErr) begin
      expErrCnt = (expErrCnt == 255) ? 255 : expErrCnt + 1;
      expValid = 1; expErr = 1;
    end else if (op == 2) begin
      oldVal = expMem[a1];
      expAddr1 = a1; expData = d; expWren = 1; expMem[a1] = d;
      if (abort) begin
        doAbort();
        expMem[a1] = oldVal;
        ram[a1] = D'(oldVal);
        return;
      end
      @(posedge clock); #1;
      expWren = 0; expValid = 1; expErr = 0;
    end else begin
      expAddr1 = a1; expAddr2 = (op == 1) ? a2 : a1;
      if (abort) begin
        doAbort();
        return;
      end
      @(posedge clock); #1;
      @(posedge clock); #1;
      expQ1 = expMem[a1];
      expQ2 = (op == 1) ? expMem[a2] : expMem[a1];
      expValid = 1; expErr = 0;
    end
    lastQ1 = int'(bus.resp_q1); lastQ2 = int'(bus.resp_q2); lastErr = int'(bus.resp_err);
    bus.resp_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      if (offer) begin
        bus.req_valid = 1'b1;
        randomizeReq();
      end
      @(posedge clock); #1;
    end
    bus.resp_ready = 1'b1;
    @(posedge clock); #1;
    bus.resp_ready = 1'b0;
    bus.req_valid  = 1'b0;
    expValid = 0; expErr = 0; expReady = 1;
  endtask

  function automatic int randAddr();
    if ($urandom_range(0, 9) == 0) return int'($urandom_range(1020, 2**A - 1));
    return int'($urandom_range(0, 31));
  endfunction

  initial begin
    int w0;
    for (int i = 0; i < 2**A; i++) ram[i] = '0;
    for (int i = 0; i < LIMIT; i++) expMem[i] = 0;
    bus.req_valid = 1'b0; bus.resp_ready = 1'b0;
    bus.req_op = '0; bus.req_addr1 = '0; bus.req_addr2 = '0; bus.req_data = '0;
    #1 reset = 1'b0;
    @(posedge clock); @(posedge clock); #1;
    reset = 1'b1;
    checkOutput("reset_req_ready", 32'(bus.req_ready), 1);
    checkOutput("reset_err_count", 32'(bus.err_count), 0);

    w0 = wrenCount;
    applyStimulus(2, 5, 0, 'h1234, 0, 0, 0);
    checkOutput("write_wren_cycles", 32'(wrenCount - w0), 1);
    applyStimulus(0, 5, 9, 0, 1, 0, 0);
    checkOutput("read5_q1", 32'(lastQ1), 'h1234);
    checkOutput("read5_q2", 32'(lastQ2), 'h1234);
    checkOutput("read5_err", 32'(lastErr), 0);

    applyStimulus(2, 7, 0, 'hA, 0, 0, 0);
    applyStimulus(2, 9, 0, 'hB, 0, 0, 0);
    applyStimulus(1, 7, 9, 0, 0, 0, 0);
    checkOutput("pair_q1", 32'(lastQ1), 'hA);
    checkOutput("pair_q2", 32'(lastQ2), 'hB);

    w0 = wrenCount;
    applyStimulus(0, 1024, 0, 0, 0, 0, 0);
    checkOutput("oor_read_err", 32'(lastErr), 1);
    applyStimulus(3, 1, 2, 0, 0, 0, 0);
    checkOutput("rsvd_op_err", 32'(lastErr), 1);
    checkOutput("err_count_2", 32'(bus.err_count), 2);
    for (int i = 0; i < 298; i++) applyStimulus(3, i, i, 0, 0, 0, 0);
    checkOutput("err_count_sat", 32'(bus.err_count), 255);
    checkOutput("err_no_wren", 32'(wrenCount - w0), 0);

    applyStimulus(1, 1023, 1024, 0, 0, 0, 0);
    checkOutput("pair_addr2_oor", 32'(lastErr), 1);
    applyStimulus(0, 3, 2047, 0, 0, 0, 0);
    checkOutput("single_ignores_addr2", 32'(lastErr), 0);
    applyStimulus(2, 1024, 0, 'h55, 0, 0, 0);
    checkOutput("write_oor_err", 32'(lastErr), 1);
    applyStimulus(2, 1023, 0, 'h77, 0, 0, 0);
    applyStimulus(1, 1023, 1023, 0, 0, 0, 0);
    checkOutput("pair_1023_q2", 32'(lastQ2), 'h77);

    applyStimulus(0, 7, 0, 0, 10, 1, 0);
    checkOutput("hold_release_ready", 32'(bus.req_ready), 1);

    applyStimulus(0, 20, 0, 0, 0, 0, 1);
    applyStimulus(2, 21, 0, 'hBEEF, 0, 0, 1);
    applyStimulus(2, 30, 0, 'h5A5A, 0, 0, 0);
    applyStimulus(0, 30, 0, 0, 0, 0, 0);
    checkOutput("post_reset_read", 32'(lastQ1), 'h5A5A);
    checkOutput("post_reset_err_count", 32'(bus.err_count), 0);

    for (int i = 0; i < 300; i++) begin
      applyStimulus(int'($urandom_range(0, 3)), randAddr(), randAddr(),
                    int'($urandom_range(0, 2**D - 1)), int'($urandom_range(0, 3)),
                    1'($urandom), 1'($urandom_range(0, 19) == 0));
    end

    @(posedge clock); #1;
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end
endmodule
